// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and default constants for the push-button conditioner.
//   hold_state_t      : per-channel long-press / auto-repeat FSM state
//   *_DEF             : default timing constants (100 MHz system clock)
//   max_u             : constant helper used to size the shared hold counter
package debounce_pkg;

  typedef enum logic [1:0] {
    HOLD_IDLE,
    HOLD_WAIT,
    HOLD_RPT
  } hold_state_t;

  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned DB_CYCLES_DEF     = 262144;     // 2.62 ms
  localparam int unsigned LONG_CYCLES_DEF   = 100000000;  // 1 s
  localparam int unsigned REPEAT_CYCLES_DEF = 25000000;   // 250 ms

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one button channel -- synchroniser, debounce filter, press/release
// strobes and long-press / auto-repeat FSM. All outputs are registered.
//   clk, rst  : clock, asynchronous active-high reset
//   btn       : raw asynchronous button level
//   rpt_en    : auto-repeat enable (synchronous)
//   state     : debounced level, 1 = pressed
//   ondn/onup : 1-cycle press / release strobes
//   long_stb  : 1-cycle long-press strobe
//   rpt_stb   : 1-cycle auto-repeat strobe
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic rpt_en,
  output logic state,
  output logic ondn,
  output logic onup,
  output logic long_stb,
  output logic rpt_stb
);

  localparam int unsigned DbW   = $clog2(DB_CYCLES);
  localparam int unsigned HoldW = $clog2(max_u(LONG_CYCLES, REPEAT_CYCLES));

  localparam logic [DbW-1:0]   DbLast   = DbW'(DB_CYCLES - 1);
  localparam logic [HoldW-1:0] LongLast = HoldW'(LONG_CYCLES - 1);
  localparam logic [HoldW-1:0] RptLast  = HoldW'(REPEAT_CYCLES - 1);

  // Chain resets to the released raw level so no edge is seen coming out of reset.
  localparam logic [SYNC_STAGES-1:0] SyncRst = ACTIVE_LOW ? '1 : '0;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  logic                   state_q, state_d;
  logic [DbW-1:0]         db_cnt_q, db_cnt_d;
  hold_state_t            hold_q, hold_d;
  logic [HoldW-1:0]       hold_cnt_q, hold_cnt_d;
  logic                   ondn_q, ondn_d;
  logic                   onup_q, onup_d;
  logic                   long_q, long_d;
  logic                   rpt_q, rpt_d;
  logic                   toggle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= SyncRst;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
    end
  end

  assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;
    ondn_d     = 1'b0;
    onup_d     = 1'b0;
    long_d     = 1'b0;
    rpt_d      = 1'b0;
    toggle     = 1'b0;

    // Debounce: any agreement with the current level restarts the filter.
    if (s == state_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbLast) begin
      toggle   = 1'b1;
      state_d  = ~state_q;
      db_cnt_d = '0;
      ondn_d   = ~state_q;
      onup_d   = state_q;
    end else begin
      db_cnt_d = db_cnt_q + DbW'(1);
    end

    // Level changes override the hold timer, so a release never carries long/rpt.
    if (toggle && !state_q) begin
      hold_d     = HOLD_WAIT;
      hold_cnt_d = '0;
    end else if (toggle && state_q) begin
      hold_d     = HOLD_IDLE;
      hold_cnt_d = '0;
    end else begin
      case (hold_q)
        HOLD_WAIT: begin
          if (hold_cnt_q == LongLast) begin
            hold_d     = HOLD_RPT;
            hold_cnt_d = '0;
            long_d     = 1'b1;
            rpt_d      = rpt_en;
          end else begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
          end
        end
        HOLD_RPT: begin
          // Counter free-runs regardless of rpt_en to keep the cadence fixed.
          if (hold_cnt_q == RptLast) begin
            hold_cnt_d = '0;
            rpt_d      = rpt_en;
          end else begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
          end
        end
        default: begin
          hold_d     = HOLD_IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= 1'b0;
      db_cnt_q   <= '0;
      hold_q     <= HOLD_IDLE;
      hold_cnt_q <= '0;
      ondn_q     <= 1'b0;
      onup_q     <= 1'b0;
      long_q     <= 1'b0;
      rpt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
      ondn_q     <= ondn_d;
      onup_q     <= onup_d;
      long_q     <= long_d;
      rpt_q      <= rpt_d;
    end
  end

  assign state    = state_q;
  assign ondn     = ondn_q;
  assign onup     = onup_q;
  assign long_stb = long_q;
  assign rpt_stb  = rpt_q;

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: NUM_BTNS independent push-button conditioners.
//   clk, rst  : clock, asynchronous active-high reset
//   i_btn     : raw asynchronous button levels
//   i_rpt_en  : per-channel auto-repeat enable
//   o_state   : debounced levels, 1 = pressed
//   o_ondn    : press strobes         o_onup : release strobes
//   o_long    : long-press strobes    o_rpt  : auto-repeat strobes
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_BTNS      = 5,
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] i_btn,
  input  logic [NUM_BTNS-1:0] i_rpt_en,
  output logic [NUM_BTNS-1:0] o_state,
  output logic [NUM_BTNS-1:0] o_ondn,
  output logic [NUM_BTNS-1:0] o_onup,
  output logic [NUM_BTNS-1:0] o_long,
  output logic [NUM_BTNS-1:0] o_rpt
);

  if (NUM_BTNS < 1) begin : g_bad_num
    $error("NUM_BTNS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (DB_CYCLES < 2) begin : g_bad_db
    $error("DB_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("LONG_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_rpt
    $error("REPEAT_CYCLES must be >= 2");
  end

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DB_CYCLES    (DB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .btn     (i_btn[g]),
      .rpt_en  (i_rpt_en[g]),
      .state   (o_state[g]),
      .ondn    (o_ondn[g]),
      .onup    (o_onup[g]),
      .long_stb(o_long[g]),
      .rpt_stb (o_rpt[g])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed bench for debounce_bank with short timing parameters.
// An active-high build (dut) and an active-low build (dut_al) share clock and reset.
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn, rpt_en, btn_al;
  logic [1:0] o_state, o_ondn, o_onup, o_long, o_rpt;
  logic [1:0] al_state, al_ondn, al_onup, al_long, al_rpt;

  always #5 clk = ~clk;

  debounce_bank #(
    .NUM_BTNS(2), .SYNC_STAGES(2), .DB_CYCLES(8), .LONG_CYCLES(20), .REPEAT_CYCLES(5),
    .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .i_btn(btn), .i_rpt_en(rpt_en), .o_state(o_state),
    .o_ondn(o_ondn), .o_onup(o_onup), .o_long(o_long), .o_rpt(o_rpt)
  );

  debounce_bank #(
    .NUM_BTNS(2), .SYNC_STAGES(2), .DB_CYCLES(8), .LONG_CYCLES(20), .REPEAT_CYCLES(5),
    .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .rst(rst), .i_btn(btn_al), .i_rpt_en(2'b11), .o_state(al_state),
    .o_ondn(al_ondn), .o_onup(al_onup), .o_long(al_long), .o_rpt(al_rpt)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Channel-0 event tallies for dut (cleared per test), sampled on the falling edge.
  int ondn_n, onup_n, long_n, rpt_n;
  int ondn_at, onup_at, long_at;
  int rpt_at[$];
  int ch1_n = 0;
  int al_ev0 = 0, al_ev1 = 0, al_ondn0_n = 0, al_ondn0_at = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (o_ondn[0]) begin ondn_n++; ondn_at = cyc; end
    if (o_onup[0]) begin onup_n++; onup_at = cyc; end
    if (o_long[0]) begin long_n++; long_at = cyc; end
    if (o_rpt[0])  begin rpt_n++;  rpt_at.push_back(cyc); end
    if (o_state[1] | o_ondn[1] | o_onup[1] | o_long[1] | o_rpt[1]) ch1_n++;
    if (al_ondn[0] | al_onup[0] | al_long[0] | al_rpt[0]) al_ev0++;
    if (al_state[1] | al_ondn[1] | al_onup[1] | al_long[1] | al_rpt[1]) al_ev1++;
    if (al_ondn[0]) begin al_ondn0_n++; al_ondn0_at = cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clr();
    ondn_n = 0; onup_n = 0; long_n = 0; rpt_n = 0;
    ondn_at = 0; onup_at = 0; long_at = 0;
    rpt_at.delete();
  endtask

  // Advance to 1 time unit after the posedge that brings cyc to c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  int c0, b0, t, r, a0, snap;

  initial begin
    rst = 1'b1; btn = 2'b00; rpt_en = 2'b00; btn_al = 2'b11;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {o_state, o_ondn, o_onup, o_long, o_rpt}, 0);
    chk("reset_outputs_al", {al_state, al_ondn, al_onup, al_long, al_rpt}, 0);
    rst = 1'b0;
    goto(cyc + 2);

    // 1. Clean press.
    clr();
    c0 = cyc; btn[0] = 1'b1;
    goto(c0 + 15);
    chk("t1_ondn_count", ondn_n, 1);
    chk("t1_ondn_cycle", ondn_at, c0 + 10);
    chk("t1_state", o_state, 2'b01);
    chk("t1_onup_count", onup_n, 0);
    btn[0] = 1'b0; rpt_en[0] = 1'b1;
    goto(cyc + 14);
    chk("t1_release_state", o_state, 2'b00);
    chk("t1_release_onup", onup_n, 1);

    // 2. Bounce, then hold.
    clr();
    b0 = cyc;
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~btn[0];
      goto(b0 + 3 * (i + 1));
    end
    chk("t2_bounce_quiet", ondn_n + onup_n + long_n + rpt_n, 0);
    btn[0] = 1'b1;
    goto(b0 + 41);
    chk("t2_ondn_count", ondn_n, 1);
    chk("t2_ondn_cycle", ondn_at, b0 + 40);

    // 3. Long hold with repeat enabled; o_state falls at T+48.
    t = b0 + 40;
    goto(t + 38);
    btn[0] = 1'b0;
    goto(t + 60);
    chk("t3_long_count", long_n, 1);
    chk("t3_long_cycle", long_at, t + 20);
    chk("t3_rpt_count", rpt_n, 6);
    for (int i = 0; i < 6; i++)
      chk("t3_rpt_cycle", (i < rpt_at.size()) ? rpt_at[i] : -1, t + 20 + 5 * i);
    chk("t3_onup_cycle", onup_at, t + 48);
    chk("t3_state", o_state, 2'b00);

    // 4. Repeat disabled, enabled at T+32.
    clr();
    rpt_en[0] = 1'b0;
    c0 = cyc; btn[0] = 1'b1; t = c0 + 10;
    goto(t + 32);
    rpt_en[0] = 1'b1;
    goto(t + 38);
    btn[0] = 1'b0;
    goto(t + 60);
    chk("t4_long_count", long_n, 1);
    chk("t4_rpt_count", rpt_n, 3);
    for (int i = 0; i < 3; i++)
      chk("t4_rpt_cycle", (i < rpt_at.size()) ? rpt_at[i] : -1, t + 35 + 5 * i);

    // 5. Async reset mid-hold.
    clr();
    c0 = cyc; btn[0] = 1'b1; t = c0 + 10;
    goto(t + 23);
    chk("t5_long_before_reset", long_n, 1);
    rst = 1'b1;
    #1;
    chk("t5_async_clear", {o_state, o_ondn, o_onup, o_long, o_rpt}, 0);
    clr();
    goto(t + 25);
    rst = 1'b0; r = cyc;
    goto(r + 35);
    chk("t5_ondn_count", ondn_n, 1);
    chk("t5_ondn_cycle", ondn_at, r + 10);
    chk("t5_long_cycle", long_at, r + 30);
    chk("t5_no_onup", onup_n, 0);
    btn[0] = 1'b0;
    goto(cyc + 15);
    chk("ch1_idle", ch1_n, 0);

    // 6. Active-low build.
    chk("t6_al_quiet", al_ev0 + al_ev1, 0);
    chk("t6_al_state_idle", al_state, 2'b00);
    a0 = cyc; btn_al[0] = 1'b0; btn_al[1] = 1'b1;
    goto(a0 + 15);
    chk("t6_al_ondn_count", al_ondn0_n, 1);
    chk("t6_al_ondn_cycle", al_ondn0_at, a0 + 10);
    chk("t6_al_state", al_state, 2'b01);
    chk("t6_al_ch1_quiet", al_ev1, 0);
    btn_al[0] = 1'b1;
    goto(cyc + 15);
    chk("t6_al_released", al_state, 2'b00);
    snap = al_ev0;
    rst = 1'b1;
    goto(cyc + 2);
    rst = 1'b0;
    goto(cyc + 15);
    chk("t6_al_reset_no_strobe", al_ev0 - snap, 0);
    chk("t6_al_ch1_after_reset", al_ev1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
